cjump_rs: RTL and testbench

//  Reservation station feeding the conditional-jump FU: the issue-side end of its input interface.

---
 rtl/cjump_rs.sv | 124 ++++++++++++
 tb/tb_cjump_rs.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cjump_rs.sv
// cjump_rs: reservation station for the conditional-jump FU (compacting age-ordered queue, CDB snoop, oldest-ready issue)
module cjump_rs #(
  parameter int DEPTH   = 4,
  parameter int ROBID_W = 4,
  parameter int DATA_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [DATA_W-1:0]            disp_operand,
  input  logic [1:0]                   disp_dep_rdy,
  input  logic [2*ROBID_W-1:0]         disp_dep_tag,
  input  logic [2*DATA_W-1:0]          disp_dep_val,
  input  logic [DATA_W-1:0]            disp_wbs,
  input  logic [DATA_W-1:0]            disp_flags,
  input  logic [ROBID_W-1:0]           disp_robid,
  input  logic                         cdb_valid,
  input  logic [ROBID_W-1:0]           cdb_id,
  input  logic [DATA_W-1:0]            cdb_val,
  input  logic                         fu_busy,
  output logic                         issue_transmit,
  output logic [DATA_W-1:0]            issue_operand,
  output logic [2*DATA_W-1:0]          issue_depvals,
  output logic [DATA_W-1:0]            issue_wbs,
  output logic [DATA_W-1:0]            issue_flags,
  output logic [ROBID_W-1:0]           issue_robid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic                       v;
    logic [DATA_W-1:0]          op;
    logic [DATA_W-1:0]          wbs;
    logic [DATA_W-1:0]          fl;
    logic [ROBID_W-1:0]         rob;
    logic [1:0]                 rdy;
    logic [1:0][ROBID_W-1:0]    tag;
    logic [1:0][DATA_W-1:0]     val;
  } ent_t;
  ent_t ent_q [DEPTH];
  ent_t ent_d [DEPTH];
  ent_t new_ent;
  logic [CW-1:0] count_q, count_d, widx;
  logic [IW-1:0] sel;
  logic found, issue, accept;
  logic tx_q;
  logic [DATA_W-1:0] op_q, wbs_q, fl_q;
  logic [2*DATA_W-1:0] dv_q;
  logic [ROBID_W-1:0] rob_q;
  assign disp_ready = count_q != CW'(DEPTH);
  assign count = count_q;
  assign issue_transmit = tx_q;
  assign issue_operand = op_q;
  assign issue_depvals = dv_q;
  assign issue_wbs = wbs_q;
  assign issue_flags = fl_q;
  assign issue_robid = rob_q;
  always_comb begin
    new_ent = '0;
    new_ent.v = 1'b1;
    new_ent.op = disp_operand;
    new_ent.wbs = disp_wbs;
    new_ent.fl = disp_flags;
    new_ent.rob = disp_robid;
    new_ent.rdy = disp_dep_rdy;
    new_ent.tag = disp_dep_tag;
    new_ent.val = disp_dep_val;
  end
  // Downward scan so the lowest (oldest) ready index wins.
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (ent_q[i].v && &ent_q[i].rdy) begin
        found = 1'b1;
        sel = IW'(i);
      end
  end
  assign issue = found && !fu_busy && !tx_q;
  assign accept = disp_valid && disp_ready;
  assign widx = count_q - CW'(issue);
  assign count_d = count_q + CW'(accept) - CW'(issue);
  // Compact first, then insert the new op, then let the CDB act on the resulting positions.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH-1; i++)
      if (issue && IW'(i) >= sel) ent_d[i] = ent_q[i+1];
    if (issue) ent_d[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++)
      if (accept && CW'(i) == widx) ent_d[i] = new_ent;
    for (int i = 0; i < DEPTH; i++)
      for (int s = 0; s < 2; s++)
        if (cdb_valid && ent_d[i].v && !ent_d[i].rdy[s] && ent_d[i].tag[s] == cdb_id) begin
          ent_d[i].rdy[s] = 1'b1;
          ent_d[i].val[s] = cdb_val;
        end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      tx_q <= 1'b0;
      op_q <= '0;
      dv_q <= '0;
      wbs_q <= '0;
      fl_q <= '0;
      rob_q <= '0;
    end else begin
      ent_q <= ent_d;
      count_q <= count_d;
      tx_q <= issue;
      if (issue) begin
        op_q <= ent_q[sel].op;
        dv_q <= ent_q[sel].val;
        wbs_q <= ent_q[sel].wbs;
        fl_q <= ent_q[sel].fl;
        rob_q <= ent_q[sel].rob;
      end
    end
  end
endmodule

// File: tb/tb_cjump_rs.sv
// tb_cjump_rs: directed bench with a queue-level reference model for cjump_rs
module tb_cjump_rs;
  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready, cdb_valid, fu_busy, issue_transmit;
  logic [7:0] disp_operand, disp_wbs, disp_flags, cdb_val, issue_operand, issue_wbs, issue_flags;
  logic [1:0] disp_dep_rdy;
  logic [7:0] disp_dep_tag;
  logic [15:0] disp_dep_val, issue_depvals;
  logic [3:0] disp_robid, cdb_id, issue_robid;
  logic [2:0] count;
  int checks = 0, passed = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  cjump_rs dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_operand(disp_operand), .disp_dep_rdy(disp_dep_rdy), .disp_dep_tag(disp_dep_tag),
    .disp_dep_val(disp_dep_val), .disp_wbs(disp_wbs), .disp_flags(disp_flags), .disp_robid(disp_robid),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val), .fu_busy(fu_busy),
    .issue_transmit(issue_transmit), .issue_operand(issue_operand), .issue_depvals(issue_depvals),
    .issue_wbs(issue_wbs), .issue_flags(issue_flags), .issue_robid(issue_robid), .count(count)
  );
  typedef struct packed {
    logic [7:0] op, wbs, fl;
    logic [3:0] rob;
    logic [1:0] rdy;
    logic [7:0] tag;
    logic [15:0] val;
  } m_t;
  m_t mq[$];
  bit m_tx = 0;
  logic [43:0] m_pay = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // Reference model: an age-ordered list; the oldest fully-ready op leaves, new ops join the tail.
  always @(posedge clk) begin
    int pick;
    m_t e;
    if (rst || flush) begin
      mq.delete();
      m_tx = 0;
      m_pay = '0;
    end else begin
      pick = -1;
      if (!fu_busy && !m_tx)
        for (int i = 0; i < mq.size(); i++)
          if (pick < 0 && mq[i].rdy == 2'b11) pick = i;
      m_tx = pick >= 0;
      if (disp_valid && mq.size() < 4) begin
        e = '{op: disp_operand, wbs: disp_wbs, fl: disp_flags, rob: disp_robid,
              rdy: disp_dep_rdy, tag: disp_dep_tag, val: disp_dep_val};
        if (pick >= 0) begin
          m_pay = {mq[pick].op, mq[pick].val, mq[pick].wbs, mq[pick].fl, mq[pick].rob};
          mq.delete(pick);
        end
        mq.push_back(e);
      end else if (pick >= 0) begin
        m_pay = {mq[pick].op, mq[pick].val, mq[pick].wbs, mq[pick].fl, mq[pick].rob};
        mq.delete(pick);
      end
      if (cdb_valid)
        for (int i = 0; i < mq.size(); i++) begin
          e = mq[i];
          for (int s = 0; s < 2; s++)
            if (!e.rdy[s] && e.tag[s*4 +: 4] == cdb_id) begin
              e.rdy[s] = 1'b1;
              e.val[s*8 +: 8] = cdb_val;
            end
          mq[i] = e;
        end
    end
  end
  always @(negedge clk)
    if (chk_en)
      chk("cycle", {15'd0, count, disp_ready, issue_transmit, issue_operand, issue_depvals, issue_wbs, issue_flags, issue_robid},
          {15'd0, 3'(mq.size()), mq.size() < 4, m_tx, m_pay});
  task automatic set_disp(input logic [3:0] rob, input logic [7:0] op, input logic [1:0] rdy,
                          input logic [7:0] tag, input logic [15:0] val);
    disp_valid = 1'b1;
    disp_robid = rob;
    disp_operand = op;
    disp_dep_rdy = rdy;
    disp_dep_tag = tag;
    disp_dep_val = val;
    disp_wbs = op ^ 8'h5A;
    disp_flags = {4'hA, rob};
  endtask
  task automatic cdb(input logic [3:0] id, input logic [7:0] v);
    cdb_valid = 1'b1;
    cdb_id = id;
    cdb_val = v;
  endtask
  initial begin
    rst = 1; flush = 0; disp_valid = 0; cdb_valid = 0; fu_busy = 0;
    disp_operand = 0; disp_dep_rdy = 0; disp_dep_tag = 0; disp_dep_val = 0;
    disp_wbs = 0; disp_flags = 0; disp_robid = 0; cdb_id = 0; cdb_val = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_tx", issue_transmit, 0);
    chk("rst_payload", {issue_operand, issue_depvals, issue_wbs, issue_flags, issue_robid}, 0);
    rst = 0;
    chk_en = 1;
    set_disp(4'd3, 8'h0C, 2'b11, 8'h00, 16'h8042);
    @(negedge clk);
    disp_valid = 0;
    chk("t2_count1", count, 1);
    chk("t2_tx0", issue_transmit, 0);
    @(negedge clk);
    chk("t2_tx1", issue_transmit, 1);
    chk("t2_depvals", issue_depvals, 16'h8042);
    chk("t2_robid", issue_robid, 3);
    chk("t2_operand", issue_operand, 8'h0C);
    chk("t2_count0", count, 0);
    @(negedge clk);
    chk("t2_single_pulse", issue_transmit, 0);
    chk("t2_hold_robid", issue_robid, 3);
    set_disp(4'd5, 8'h03, 2'b01, 8'h20, 16'hFF11);
    @(negedge clk);
    disp_valid = 0;
    cdb(4'd2, 8'h00);
    @(negedge clk);
    cdb_valid = 0;
    chk("t3_tx0", issue_transmit, 0);
    @(negedge clk);
    chk("t3_tx1", issue_transmit, 1);
    chk("t3_depvals", issue_depvals, 16'h0011);
    chk("t3_robid", issue_robid, 5);
    @(negedge clk);
    set_disp(4'd5, 8'h03, 2'b01, 8'h20, 16'hFF11);
    cdb(4'd2, 8'h00);
    @(negedge clk);
    disp_valid = 0;
    cdb_valid = 0;
    chk("byp_count1", count, 1);
    chk("byp_tx0", issue_transmit, 0);
    @(negedge clk);
    chk("byp_tx1", issue_transmit, 1);
    chk("byp_depvals", issue_depvals, 16'h0011);
    chk("byp_robid", issue_robid, 5);
    @(negedge clk);
    for (int r = 1; r <= 5; r++) begin
      set_disp(4'(r), 8'(8'h10 + r), 2'b01, {(r == 1 || r == 3) ? 4'd6 : (r == 2 ? 4'd8 : 4'd9), 4'd0},
               {8'h00, 8'(8'h20 + r)});
      @(negedge clk);
      if (r == 4) chk("full_ready0", disp_ready, 0);
    end
    disp_valid = 0;
    chk("full_count4", count, 4);
    chk("full_ready", disp_ready, 0);
    cdb(4'd6, 8'h77);
    @(negedge clk);
    cdb_valid = 0;
    chk("wake_tx0", issue_transmit, 0);
    @(negedge clk);
    chk("wake_tx_first", issue_transmit, 1);
    chk("wake_rob1", issue_robid, 1);
    chk("wake_dv1", issue_depvals, 16'h7721);
    @(negedge clk);
    chk("wake_gap", issue_transmit, 0);
    @(negedge clk);
    chk("wake_tx_second", issue_transmit, 1);
    chk("wake_rob3", issue_robid, 3);
    chk("wake_count2", count, 2);
    fu_busy = 1;
    cdb(4'd8, 8'h88);
    @(negedge clk);
    cdb(4'd9, 8'h99);
    @(negedge clk);
    cdb_valid = 0;
    repeat (2) @(negedge clk);
    chk("busy_tx0", issue_transmit, 0);
    chk("busy_count2", count, 2);
    fu_busy = 0;
    @(negedge clk);
    chk("busy_rel_tx", issue_transmit, 1);
    chk("busy_rel_rob2", issue_robid, 2);
    chk("busy_rel_dv2", issue_depvals, 16'h8822);
    @(negedge clk);
    chk("busy_gap", issue_transmit, 0);
    @(negedge clk);
    chk("busy_rob4", issue_robid, 4);
    chk("busy_dv4", issue_depvals, 16'h9924);
    chk("busy_count0", count, 0);
    fu_busy = 1;
    for (int r = 10; r <= 12; r++) begin
      set_disp(4'(r), 8'(r), 2'b11, 8'h00, {8'(8'hA0 + r), 8'(8'hB0 + r)});
      @(negedge clk);
    end
    disp_valid = 0;
    fu_busy = 0;
    @(negedge clk);
    chk("fl_tx", issue_transmit, 1);
    chk("fl_rob10", issue_robid, 10);
    chk("fl_count2", count, 2);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("fl_count0", count, 0);
    chk("fl_tx0", issue_transmit, 0);
    chk("fl_payload0", issue_robid, 0);
    repeat (4) @(negedge clk);
    chk("fl_quiet_count", count, 0);
    chk("fl_quiet_tx", issue_transmit, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
